// File: rtl/uart_pkg.sv
// Shared constants and drain FSM encoding for the UART transmit FIFO.
package uart_pkg;

  localparam int BYTE_W     = 8;
  localparam int TX_TIMEOUT = 4;
  localparam int TMR_W      = 3;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TX_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } drain_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the TX FIFO: synchronous write port, asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [BYTE_W-1:0]     wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [BYTE_W-1:0]     rdata_o
);

  logic [BYTE_W-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus drain controller feeding a UART transmitter one byte at a time.
// Optional refill flag tx_low is built only when UART_TX_FIFO_LOW_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int LOW_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BYTE_W-1:0]     wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  ovf_clr,
`ifdef UART_TX_FIFO_LOW_EN
  output logic                  tx_low,
`endif
  output logic [BYTE_W-1:0]     tx_data,
  output logic                  tx_wr,
  input  logic                  tx_busy,
  output logic [1:0]            dbg_state_o
);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [BYTE_W-1:0]     tx_data_q;
  logic                  tx_wr_q;
  logic [TMR_W-1:0]      timer_q;
  drain_state_e          state_q;
  logic [BYTE_W-1:0]     rd_data;
  logic                  push_ok;
  logic                  pop;

  // Count never exceeds the depth, so its MSB alone marks a full queue.
  assign full    = count_q[DEPTH_LOG2];
  assign empty   = (count_q == '0);
  assign push_ok = wr_en & ~full;
  assign pop     = (state_q == ST_IDLE) & ~empty & ~tx_busy;

  uart_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk     (clk),
    .we_i    (push_ok & reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (wr_en & full) ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // UART handshake: tx_wr is a one-cycle strobe offered only while tx_busy is
  // low; the UART acknowledges by raising tx_busy and finishes by dropping it.
  // A UART that never raises tx_busy is abandoned after TX_TIMEOUT cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      timer_q   <= '0;
      state_q   <= ST_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      tx_wr_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            tx_data_q <= rd_data;
            tx_wr_q   <= 1'b1;
            timer_q   <= '0;
            state_q   <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (tx_busy)                  state_q <= ST_WAIT_DONE;
          else if (timer_q == TMR_LAST) state_q <= ST_IDLE;
          else                          timer_q <= timer_q + TMR_ONE;
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_LOW_EN
  logic tx_low_q;
  always_ff @(posedge clk) begin
    if (!reset) tx_low_q <= 1'b1;
    else        tx_low_q <= (int'(count_d) <= LOW_THRESH);
  end
  assign tx_low = tx_low_q;
`else
  logic unused_low_thresh;
  assign unused_low_thresh = ^LOW_THRESH;
`endif

  assign level       = count_q;
  assign overflow    = ovf_q;
  assign tx_data     = tx_data_q;
  assign tx_wr       = tx_wr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed steps plus random traffic against a queue model.
// Also checks tx_low when UART_TX_FIFO_LOW_EN is defined.
module tb_uart_tx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int LOW_THRESH = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [7:0]          wr_data;
  logic                wr_en;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic                ovf_clr;
`ifdef UART_TX_FIFO_LOW_EN
  logic                tx_low;
`endif
  logic [7:0]          tx_data;
  logic                tx_wr;
  logic                tx_busy;
  logic [1:0]          dbg_state;

  uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .LOW_THRESH(LOW_THRESH)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
`ifdef UART_TX_FIFO_LOW_EN
    .tx_low      (tx_low),
`endif
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_busy     (tx_busy),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard and reference model state
  logic [7:0] exp_q[$];
  int         stb_t[$];
  int         level_m   = 0;
  logic       ovf_m     = 1'b0;
  logic [7:0] last_data = 8'h00;
  int         tests     = 0;
  int         fails     = 0;
  int         tick_no   = 0;
  int         strobes   = 0;
  logic       prev_wr   = 1'b0;

  // UART model controls
  logic uart_resp = 1'b1;
  logic busy_rand = 1'b0;
  int   busy_len  = 3;
  int   uart_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then check.
  task automatic tick();
    int         sz_before;
    logic       acc;
    logic [7:0] exp_b;
    @(posedge clk);
    sz_before = exp_q.size();
    if (!reset) begin
      exp_q.delete();
      level_m   = 0;
      ovf_m     = 1'b0;
      last_data = 8'h00;
    end else begin
      acc = wr_en && (level_m < DEPTH);
      if (wr_en && !acc) ovf_m = 1'b1;
      else if (ovf_clr)  ovf_m = 1'b0;
      if (acc) begin
        exp_q.push_back(wr_data);
        level_m++;
      end
    end
    #1;
    tick_no++;
    if (tx_wr === 1'b1) begin
      strobes++;
      stb_t.push_back(tick_no);
      chk("strobe_allowed", {31'b0, (reset === 1'b1) && (sz_before > 0)}, 32'd1);
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        chk("tx_data_order", {24'b0, tx_data}, {24'b0, exp_b});
        last_data = exp_b;
        level_m--;
      end
    end else begin
      chk("tx_data_hold", {24'b0, tx_data}, {24'b0, last_data});
    end
    if (prev_wr) chk("tx_wr_one_cycle", {31'b0, tx_wr}, 32'd0);
    chk("level", {27'b0, level}, level_m);
    chk("full", {31'b0, full}, {31'b0, level_m == DEPTH});
    chk("empty", {31'b0, empty}, {31'b0, level_m == 0});
    chk("overflow", {31'b0, overflow}, {31'b0, ovf_m});
`ifdef UART_TX_FIFO_LOW_EN
    chk("tx_low", {31'b0, tx_low}, {31'b0, level_m <= LOW_THRESH});
`endif
    // UART model: busy one cycle after the strobe, held for busy_len cycles
    if (uart_resp && prev_wr) begin
      tx_busy  = 1'b1;
      uart_cnt = busy_rand ? $urandom_range(1, 5) : busy_len;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) tx_busy = 1'b0;
    end
    prev_wr = (tx_wr === 1'b1);
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic drain();
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) tick();
    chk("drain_done", exp_q.size(), 0);
    repeat (12) tick();
  endtask

  int s0;

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    tx_busy = 1'b0;

    // reset
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_level", {27'b0, level}, 32'd0);
    chk("rst_tx_wr", {31'b0, tx_wr}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);

    // single byte, long UART busy
    busy_len = 160;
    push(8'hA5);
    chk("single_not_empty", {31'b0, empty}, 32'd0);
    chk("single_no_early_wr", {31'b0, tx_wr}, 32'd0);
    s0 = strobes;
    tick();
    chk("single_wr", {31'b0, tx_wr}, 32'd1);
    chk("single_data", {24'b0, tx_data}, 32'hA5);
    chk("single_level", {27'b0, level}, 32'd0);
    repeat (170) tick();
    chk("single_one_strobe", strobes - s0, 32'd1);
    busy_len = 3;

    // burst into a busy UART, overflow, set-wins-over-clear
    tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("burst_full", {31'b0, full}, 32'd1);
    chk("burst_level", {27'b0, level}, 32'd16);
    push(8'hFF);
    chk("burst_ovf_set", {31'b0, overflow}, 32'd1);
    chk("burst_level_kept", {27'b0, level}, 32'd16);
    ovf_clr = 1'b1;
    push(8'hEE);
    chk("ovf_set_wins", {31'b0, overflow}, 32'd1);
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'b0, overflow}, 32'd0);
    tx_busy = 1'b0;
    drain();

    // push and pop on the same edge at level 3
    tx_busy = 1'b1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("pp_level3", {27'b0, level}, 32'd3);
    tx_busy = 1'b0;
    push(8'h44);
    chk("pp_strobe", {31'b0, tx_wr}, 32'd1);
    chk("pp_level_kept", {27'b0, level}, 32'd3);
    drain();

    // reset mid-transfer discards queued bytes
    tx_busy = 1'b1;
    push(8'h51);
    push(8'h52);
    push(8'h53);
    reset = 1'b0;
    tick();
    reset   = 1'b1;
    tx_busy = 1'b0;
    tick();
    chk("midrst_level", {27'b0, level}, 32'd0);
    chk("midrst_empty", {31'b0, empty}, 32'd1);
    repeat (10) tick();

    // UART that ignores the strobe
    uart_resp = 1'b0;
    stb_t.delete();
    push(8'h3C);
    push(8'h77);
    repeat (20) tick();
    chk("timeout_strobes", stb_t.size(), 32'd2);
    if (stb_t.size() >= 2) chk("timeout_gap", stb_t[1] - stb_t[0], 32'd5);
    uart_resp = 1'b1;
    drain();

`ifdef UART_TX_FIFO_LOW_EN
    // fill to five then drain through the threshold
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    chk("low_at5", {31'b0, tx_low}, 32'd0);
    tx_busy = 1'b0;
    drain();
    chk("low_at0", {31'b0, tx_low}, 32'd1);
`endif

    // random traffic
    busy_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom_range(0, 99) < 40);
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 19) == 0);
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
